// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with shadowed loader parameters.
// Optional refractory period after each fire when LIF_REFRACTORY_EN is defined.
module lif_neuron #(
  parameter int unsigned REFRAC_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_vars,
  input  logic [7:0] tau,
  input  logic [7:0] weight,
  input  logic [7:0] threshold,
  input  logic       spike_in,
  output logic [7:0] membrane,
  output logic       spike_out,
  output logic [7:0] spike_count,
  output logic       busy
);
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REFRAC = 2'd2;
`ifdef LIF_REFRACTORY_EN
  localparam logic REFRAC_EN = 1'b1;
`else
  localparam logic REFRAC_EN = 1'b0;
`endif
  localparam logic GO_REFRAC = REFRAC_EN && (REFRAC_CYCLES != 0);
  logic [1:0] state;
  logic       set_vars_d;
  logic [7:0] tau_s, weight_s, threshold_s;
  logic [3:0] s;
  logic [7:0] leak, sum;
  logic [8:0] raw;
  logic       fire, refrac_done;
  always_comb begin
    s = tau_s[3:0];
    leak = (s >= 4'd1 && s <= 4'd7) ? membrane >> s : 8'd0;
    raw = {1'b0, membrane - leak} + {1'b0, spike_in ? weight_s : 8'd0};
    sum = raw[8] ? 8'hff : raw[7:0];
    fire = threshold_s != 8'd0 && sum >= threshold_s;
  end
`ifdef LIF_REFRACTORY_EN
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= 8'd0;
    else if (set_vars) cnt <= 8'd0;
    else if (state == RUN && !set_vars_d && fire) cnt <= 8'(REFRAC_CYCLES);
    else if (state == REFRAC) cnt <= cnt - 8'd1;
  assign refrac_done = cnt == 8'd1;
`else
  assign refrac_done = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= RUN;
      set_vars_d  <= 1'b0;
      tau_s       <= 8'd0;
      weight_s    <= 8'd0;
      threshold_s <= 8'd0;
      membrane    <= 8'd0;
      spike_out   <= 1'b0;
      spike_count <= 8'd0;
    end else begin
      set_vars_d <= set_vars;
      spike_out  <= 1'b0;
      if (set_vars) begin
        state    <= HOLD;
        membrane <= 8'd0;
      end else if (set_vars_d) begin
        state       <= RUN;
        tau_s       <= tau;
        weight_s    <= weight;
        threshold_s <= threshold;
      end else if (state == RUN) begin
        membrane <= fire ? 8'd0 : sum;
        if (fire) begin
          spike_out   <= 1'b1;
          spike_count <= spike_count + 8'd1;
          state       <= GO_REFRAC ? REFRAC : RUN;
        end
      end else if (state == REFRAC && refrac_done) state <= RUN;
    end
  assign busy = state != RUN;
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: directed bench with a cycle-level behavioural model of the neuron.
module tb_lif_neuron;
`ifdef LIF_REFRACTORY_EN
  localparam int RC = 4;
`else
  localparam int RC = 0;
`endif
  logic clk = 1'b0, rst = 1'b0, set_vars = 1'b0, spike_in = 1'b0;
  logic [7:0] tau = 8'd0, weight = 8'd0, threshold = 8'd0;
  logic [7:0] membrane, spike_count;
  logic spike_out, busy;
  int passed = 0, total = 0;
  bit chk_en = 1'b0;
  int m_v = 0, m_cnt = 0, m_refr = 0, m_tau = 0, m_w = 0, m_th = 0;
  bit m_hold = 0, m_prev = 0, m_spk = 0;

  lif_neuron #(.REFRAC_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .set_vars(set_vars), .tau(tau), .weight(weight),
    .threshold(threshold), .spike_in(spike_in), .membrane(membrane),
    .spike_out(spike_out), .spike_count(spike_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_v = 0; m_cnt = 0; m_refr = 0; m_tau = 0; m_w = 0; m_th = 0;
    m_hold = 0; m_prev = 0; m_spk = 0;
  endtask

  task automatic model_step(input bit sv, input bit si);
    int sh, lk, sm;
    m_spk = 0;
    if (sv) begin
      m_hold = 1; m_v = 0; m_refr = 0;
    end else if (m_prev) begin
      m_hold = 0; m_tau = tau; m_w = weight; m_th = threshold;
    end else if (m_refr > 0) begin
      m_refr--;
    end else begin
      sh = m_tau % 16;
      lk = (sh >= 1 && sh <= 7) ? m_v / (1 << sh) : 0;
      sm = m_v - lk + (si ? m_w : 0);
      if (sm > 255) sm = 255;
      if (m_th != 0 && sm >= m_th) begin
        m_v = 0; m_spk = 1; m_cnt++; m_refr = RC;
      end else m_v = sm;
    end
    m_prev = sv;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("membrane", membrane, m_v);
    chk("spike_out", spike_out, m_spk);
    chk("spike_count", spike_count, m_cnt % 256);
    chk("busy", busy, (m_hold || m_refr > 0) ? 1 : 0);
  end

  task automatic cyc(input bit sv, input bit si);
    set_vars = sv; spike_in = si;
    @(posedge clk);
    if (rst) model_step(sv, si);
    #1;
  endtask

  task automatic cfg(input int t, input int w, input int th);
    tau = 8'(t); weight = 8'(w); threshold = 8'(th);
    cyc(1, 0);
    chk("cfg_busy", busy, 1);
    cyc(0, 0);
  endtask

  initial begin
    int c0;
    #1 chk_en = 1'b1;
    #22 rst = 1'b1;
    chk("reset_membrane", membrane, 0);
    chk("reset_count", spike_count, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1);
    chk("unconfigured_no_fire", spike_count, 0);
    cfg(2, 40, 100);
    cyc(0, 1); chk("leak_40", membrane, 40);
    cyc(0, 1); chk("leak_70", membrane, 70);
    cyc(0, 1); chk("leak_93", membrane, 93);
    cyc(0, 1); chk("leak_fire", spike_out, 1); chk("leak_fire_v", membrane, 0);
    chk("leak_fire_cnt", spike_count, 1);
`ifdef LIF_REFRACTORY_EN
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1); chk("refrac_ignored", membrane, 0);
    end
`endif
    cyc(0, 1); chk("post_fire_40", membrane, 40);
    cyc(0, 1); cyc(0, 1); chk("pre_reset_93", membrane, 93);
    rst = 1'b0; model_reset();
    #1 chk("async_reset_v", membrane, 0);
    chk("async_reset_cnt", spike_count, 0);
    chk("async_reset_spk", spike_out, 0);
    cyc(0, 1); cyc(0, 1);
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 1);
    chk("after_reset_no_fire", spike_count, 0);
    cfg(2, 40, 100);
    for (int i = 0; i < 4; i++) cyc(0, 1);
    chk("refire", spike_out, 1);
    weight = 8'd10;
    cyc(1, 1); chk("cfg_mid_busy", busy, 1); chk("cfg_mid_v", membrane, 0);
    cyc(0, 0);
    cyc(0, 1); chk("new_weight_10", membrane, 10);
    cfg(0, 200, 255);
    cyc(0, 1); chk("sat_200", membrane, 200);
    cyc(0, 1); chk("sat_fire", spike_out, 1);
    cfg(0, 40, 100);
    cyc(0, 1); cyc(0, 1); chk("cross_pre_80", membrane, 80);
    c0 = m_cnt;
    cyc(1, 1); chk("cross_setvars_nofire", spike_out, 0); chk("cross_setvars_v", membrane, 0);
    chk("cross_setvars_cnt", spike_count, c0 % 256);
    cyc(0, 0);
    cfg(0, 255, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1);
    chk("th0_v255", membrane, 255); chk("th0_nofire", spike_out, 0);
    cfg(0, 255, 1);
    c0 = m_cnt;
    cyc(0, 1); chk("b2b_first", spike_out, 1);
    cyc(0, 1);
    if (RC == 0) chk("b2b_second", spike_out, 1);
    for (int i = 0; i < 2000 && (m_cnt - c0) < 256; i++) cyc(0, 1);
    chk("wrap_fires", m_cnt - c0, 256);
    chk("wrap_count", spike_count, c0 % 256);
    cyc(0, 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron core, directly downstream of the serial parameter loader that produces `tau`, `weight` and `threshold`. It snapshots those parameters when configuration ends. Each clock it leaks its 8-bit membrane potential, adds `weight` on every input spike, and fires a one-cycle output spike on threshold crossing. After firing it can enter a refractory period.

## Interface
- `REFRAC_CYCLES`, default 4: refractory length in clocks, 0..255; only used with `LIF_REFRACTORY_EN`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `set_vars` in 1: loader configuration strobe, high while parameters are being shifted in.
- `tau` in 8: leak shift amount, parallel output of the loader.
- `weight` in 8: synaptic weight added per input spike.
- `threshold` in 8: firing threshold; 0 disables firing.
- `spike_in` in 1: input spike, sampled every rising edge.
- `membrane` out 8: current membrane potential.
- `spike_out` out 1: one-cycle pulse on fire.
- `spike_count` out 8: fires since reset, wraps 255→0.
- `busy` out 1: high in HOLD or REFRAC.

## Operation
- **States:** RUN, HOLD, REFRAC. Reset state is RUN.
- **Reset values:** `membrane`=0, `spike_out`=0, `spike_count`=0, `busy`=0. Shadow tau/weight/threshold=0, so the neuron never fires until configured.
- **Entering HOLD:** `set_vars` sampled 1 in any state → HOLD.
  - Membrane is cleared and the refractory counter is cleared.
  - `spike_in` is ignored.
- **Leaving HOLD (falling edge):** detected as `set_vars`=0 with a registered copy `set_vars_d`=1.
  - On that edge, capture `tau`, `weight`, `threshold` into shadow registers and go to RUN.
  - Integration starts on the following edge.
- **RUN, each edge:**
  - Shift amount s = shadow tau[3:0]. Leak L = V>>s if 1≤s≤7, else L=0.
  - Sum = (V−L) + (spike_in ? weight : 0), computed 9 bits wide and saturated to 255.
  - If threshold≠0 and sum ≥ threshold: fire.
    - Set V←0, `spike_out`←1, `spike_count`+1.
    - Go to REFRAC if the macro is defined and REFRAC_CYCLES>0; otherwise stay in RUN.
  - Otherwise V←sum and `spike_out`←0.
- **REFRAC:**
  - V held at 0, `spike_in` ignored, no leak.
  - The counter loads REFRAC_CYCLES on entry and decrements each edge.
  - On the edge where the counter reads 1, go to RUN. RUN integration resumes on the next edge.
- **Edge cases:**
  - Leak never underflows, since L≤V.
  - V=0 with no spike stays 0.

## Timing
- All outputs are registered.
- `spike_out` goes high immediately after the edge that computed the crossing and stays high exactly one cycle.
- Back-to-back fires are possible without refractory, e.g. weight≥threshold with continuous spikes → `spike_out` high every cycle.
- Latency from `spike_in` to a `membrane` update: 1 edge.
- Configuration latency: parameters are in effect one edge after `set_vars` is first sampled low.
- Priority, highest first: `rst`, then `set_vars`=1, then HOLD exit, then fire, then integrate.
- `set_vars` asserted in the same cycle as a crossing: no fire, and membrane is cleared.
- Async reset mid-operation: all state is cleared immediately; RUN on the first edge after release.

## Configuration
- Macro `LIF_REFRACTORY_EN`.
- **Defined:** the REFRAC state and counter exist; behaviour is as above.
- **Undefined:**
  - No REFRAC state and no counter logic; REFRAC_CYCLES is ignored.
  - After a fire the neuron remains in RUN and integrates on the next edge.
  - `busy` reflects HOLD only.

## Test plan
- **Reset:** assert `rst`=0 mid-integration with membrane=93 → membrane=0, spike_count=0, `spike_out`=0 immediately. With `spike_in`=1 after release and no configuration → never fires.
- **Leaky integration:** load tau=2, weight=40, threshold=100; hold `spike_in`=1 → membrane 40, 70, 93, then fire (sum 110) → `spike_out` one cycle, membrane=0, spike_count=1.
- **Saturation:** tau=0, weight=200, threshold=255; continuous spikes → membrane 200, then fire on the 2nd spike (sum saturated to 255).
- **Refractory (macro defined, REFRAC_CYCLES=4):** after a fire, spikes on the next 4 edges are ignored and membrane stays 0. The 5th edge integrates normally, giving membrane=40. With the macro undefined, membrane=40 on the first edge after the fire.
- **Config during operation:** raise `set_vars` during REFRAC → `busy`=1, membrane=0. Change to weight=10 and drop `set_vars` → the next spike gives membrane=10.
- **Threshold zero / wrap:** threshold=0 → no fire even at membrane=255. Force 256 fires with weight=255, threshold=1 → spike_count wraps to 0.
